pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline. It drives the write-enable and flush inputs of the PC register, the IF/ID buffer and the ID/EX buffer. It detects load-use hazards and inserts bubbles, flushes wrong-path instructions on taken branches and jumps, and freezes the pipeline while data memory is busy. It sits beside the ID stage and observes the IF/ID and ID/EX buffer contents.

## Interface
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 = forwarding present, 2 = none); legal range 1..3
- PERF_W, 16, width of the performance counters
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifid_rs_i  in  5  rs field of the instruction in IF/ID
- ifid_rt_i  in  5  rt field of the instruction in IF/ID
- ifid_uses_rt_i  in  1  IF/ID instruction reads rt (R-type, store, branch)
- idex_mem_read_i  in  1  memRead of the instruction in ID/EX
- idex_rt_i  in  5  rt (load destination) of the instruction in ID/EX
- id_jump_i  in  1  jump decoded in ID
- ex_branch_taken_i  in  1  branch resolved taken in EX
- mem_busy_i  in  1  data memory not ready this cycle
- pc_write_o  out  1  PC load enable
- ifid_write_o  out  1  IF/ID buffer load enable
- ifid_flush_o  out  1  IF/ID loads a NOP
- idex_flush_o  out  1  ID/EX loads all control fields as 0 (bubble)
- pipe_freeze_o  out  1  hold the ID/EX and later buffers
- state_o  out  2  current FSM state, for debug
- stall_cnt_o  out  PERF_W  stall-cycle counter
- flush_cnt_o  out  PERF_W  flush-event counter

## Operation
- FSM states: RUN (00), LOAD_STALL (01), MEM_WAIT (10). Encoding 11 is unused and recovers to RUN on the next edge.
- Load-use hazard is true when all of the following hold:
  - idex_mem_read_i = 1
  - idex_rt_i != 0
  - idex_rt_i == ifid_rs_i, or (ifid_uses_rt_i = 1 and idex_rt_i == ifid_rt_i)
- Priority, highest first: mem_busy_i, ex_branch_taken_i, id_jump_i, load-use.
- mem_busy_i = 1, any state:
  - pipe_freeze_o = 1, pc_write_o = 0, ifid_write_o = 0, all flushes 0.
  - Next state is MEM_WAIT. The return state (RUN or LOAD_STALL) and the stall counter are held.
- MEM_WAIT with mem_busy_i = 0: return to the saved state. The outputs that cycle are those of the saved state evaluated with the current inputs.
- ex_branch_taken_i = 1 (not busy): ifid_flush_o = 1, idex_flush_o = 1, pc_write_o = 1. Any pending LOAD_STALL is cancelled and the next state is RUN.
- id_jump_i = 1 (no branch, not busy): ifid_flush_o = 1, pc_write_o = 1, ifid_write_o = 1.
- Load-use in RUN:
  - pc_write_o = 0, ifid_write_o = 0, idex_flush_o = 1.
  - If LOAD_STALL_CYCLES > 1: load the remaining-bubble counter with LOAD_STALL_CYCLES-1 and go to LOAD_STALL.
- LOAD_STALL: same stall outputs as the load-use case; counter decrements each unfrozen cycle; when the counter is 1, the next state is RUN.
- No hazard in RUN: pc_write_o = 1, ifid_write_o = 1, flushes 0, freeze 0.
- All outputs are combinational from registered state plus current inputs. No output is registered.

## Timing
- Reset (rst_n low, asynchronous):
  - state = RUN, bubble counter = 0, perf counters = 0.
  - pc_write_o = 0, ifid_write_o = 0, ifid_flush_o = 1, idex_flush_o = 1, pipe_freeze_o = 0.
- Reset deassertion takes effect at the first rising edge after release. Reset during LOAD_STALL or MEM_WAIT discards the pending stall.
- Hazard response has zero-cycle latency: the stall or flush is asserted in the same cycle the condition is visible.
- A load-use hazard produces exactly LOAD_STALL_CYCLES cycles with pc_write_o = 0, excluding frozen cycles.
- A taken branch and a load-use in the same cycle: the branch wins, and no bubble counter is loaded.
- A jump and a load-use in the same cycle: the jump wins.
- mem_busy_i is sampled every cycle. A busy cycle never consumes a bubble.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt_o increments on every cycle out of reset with pc_write_o = 0.
  - flush_cnt_o increments on every cycle with ifid_flush_o = 1 out of reset.
  - Both counters saturate at all-ones.
- HAZARD_PERF_CNT_EN not defined: no counter registers; both outputs are constant 0.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum and its encodings (RUN, LOAD_STALL, MEM_WAIT)
  - the register-number width (5)
  - the default LOAD_STALL_CYCLES
- Sub-module load_use_detect: a combinational comparator producing the load-use hazard flag from the five hazard inputs, reusable by the forwarding unit.
- The FSM, bubble counter and perf counters live in pipe_hazard_ctrl.

## Test plan
- Reset: rst_n low mid-LOAD_STALL → state_o = 00, pc_write_o = 0, both flushes 1. After release with no hazard → pc_write_o = 1.
- Load-use: idex_mem_read_i = 1, idex_rt_i = 8, ifid_rs_i = 8, LOAD_STALL_CYCLES = 2 → exactly 2 cycles of pc_write_o = 0 with idex_flush_o = 1, then RUN.
- Register zero: the same case with idex_rt_i = 0 → no stall. The case ifid_rt_i = 8 with ifid_uses_rt_i = 0 → no stall.
- Branch vs load-use: ex_branch_taken_i = 1 in the same cycle as the hazard → both flushes 1, pc_write_o = 1, next state RUN.
- Memory wait: mem_busy_i = 1 for 3 cycles during LOAD_STALL → pipe_freeze_o = 1 for 3 cycles, bubble count unchanged, the stall resumes afterwards.
- Perf counters (HAZARD_PERF_CNT_EN): 2-bubble hazard plus one branch → stall_cnt_o = 2, flush_cnt_o = 1. With PERF_W = 2, 5 stalls → stall_cnt_o = 3.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encodings, register-number width and default load-use bubble count.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned DEFAULT_LOAD_STALL_CYCLES = 1;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: an in-flight load in ID/EX writes a register
// that the instruction in IF/ID reads. Register zero never creates a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             idex_mem_read_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    output logic             hazard_o
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (idex_rt_i == ifid_rs_i);
        rt_match = ifid_uses_rt_i && (idex_rt_i == ifid_rt_i);
        hazard_o = idex_mem_read_i && (idex_rt_i != '0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage pipeline: load-use bubbles,
// branch/jump flushes and memory-busy freeze. Optional perf counters: HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = DEFAULT_LOAD_STALL_CYCLES,
    parameter int unsigned PERF_W            = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  ifid_rs_i,
    input  logic [REG_W-1:0]  ifid_rt_i,
    input  logic              ifid_uses_rt_i,
    input  logic              idex_mem_read_i,
    input  logic [REG_W-1:0]  idex_rt_i,
    input  logic              id_jump_i,
    input  logic              ex_branch_taken_i,
    input  logic              mem_busy_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_flush_o,
    output logic              pipe_freeze_o,
    output logic [1:0]        state_o,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;
    state_e     cur_state;
    logic [1:0] bub_q, bub_d;
    logic       load_use;

    load_use_detect u_load_use_detect (
        .idex_mem_read_i (idex_mem_read_i),
        .idex_rt_i       (idex_rt_i),
        .ifid_rs_i       (ifid_rs_i),
        .ifid_rt_i       (ifid_rt_i),
        .ifid_uses_rt_i  (ifid_uses_rt_i),
        .hazard_o        (load_use)
    );

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        bub_d         = bub_q;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        pipe_freeze_o = 1'b0;

        // MEM_WAIT behaves as the state it interrupted; the unused code acts as RUN.
        case (state_q)
            LOAD_STALL: cur_state = LOAD_STALL;
            MEM_WAIT:   cur_state = ret_q;
            default:    cur_state = RUN;
        endcase

        if (!rst_n) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            state_d      = RUN;
            ret_d        = RUN;
            bub_d        = '0;
        end else if (mem_busy_i) begin
            pipe_freeze_o = 1'b1;
            state_d       = MEM_WAIT;
            ret_d         = cur_state;
        end else if (ex_branch_taken_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            state_d      = RUN;
            bub_d        = '0;
        end else if (id_jump_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = 1'b1;
            state_d      = RUN;
            bub_d        = '0;
        end else if (cur_state == LOAD_STALL) begin
            idex_flush_o = 1'b1;
            bub_d        = bub_q - 2'd1;
            state_d      = (bub_q <= 2'd1) ? RUN : LOAD_STALL;
        end else if (load_use) begin
            idex_flush_o = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                bub_d   = 2'(LOAD_STALL_CYCLES - 1);
                state_d = LOAD_STALL;
            end else begin
                state_d = RUN;
            end
        end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            state_d      = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ret_q   <= RUN;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            bub_q   <= bub_d;
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    // Frozen cycles do not count as stalls; both counters saturate.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (rst_n && !pc_write_o && !mem_busy_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
        if (rst_n && ifid_flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl with LOAD_STALL_CYCLES = 2,
// plus a PERF_W = 2 instance for counter saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       ifid_uses_rt, idex_mem_read, id_jump, ex_branch_taken, mem_busy;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze;
    logic [1:0] state;
    logic [15:0] stall_cnt, flush_cnt;
    logic       pc_write2, ifid_write2, ifid_flush2, idex_flush2, pipe_freeze2;
    logic [1:0] state2;
    logic [1:0] stall_cnt2, flush_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .PERF_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(ifid_uses_rt),
        .idex_mem_read_i(idex_mem_read), .idex_rt_i(idex_rt),
        .id_jump_i(id_jump), .ex_branch_taken_i(ex_branch_taken), .mem_busy_i(mem_busy),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .idex_flush_o(idex_flush), .pipe_freeze_o(pipe_freeze), .state_o(state),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .PERF_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(ifid_uses_rt),
        .idex_mem_read_i(idex_mem_read), .idex_rt_i(idex_rt),
        .id_jump_i(id_jump), .ex_branch_taken_i(ex_branch_taken), .mem_busy_i(mem_busy),
        .pc_write_o(pc_write2), .ifid_write_o(ifid_write2), .ifid_flush_o(ifid_flush2),
        .idex_flush_o(idex_flush2), .pipe_freeze_o(pipe_freeze2), .state_o(state2),
        .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2)
    );

    // Expected outputs packed as {state[1:0], pc_write, ifid_write, ifid_flush, idex_flush, freeze}
    localparam logic [6:0] E_RST   = 7'b00_00110;
    localparam logic [6:0] E_RUN   = 7'b00_11000;
    localparam logic [6:0] E_STL_R = 7'b00_00010;
    localparam logic [6:0] E_STL_L = 7'b01_00010;
    localparam logic [6:0] E_BR    = 7'b00_11110;
    localparam logic [6:0] E_JMP   = 7'b00_11100;
    localparam logic [6:0] E_FRZ_L = 7'b01_00001;
    localparam logic [6:0] E_FRZ_M = 7'b10_00001;
    localparam logic [6:0] E_RET_M = 7'b10_00010;

    typedef struct {
        logic       rst_n;
        logic       mem_read;
        logic [4:0] idex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       branch;
        logic       busy;
        logic [6:0] exp;
        string      name;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, input logic mr, input logic [4:0] irt,
                                input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                                input logic j, input logic b, input logic bz,
                                input logic [6:0] exp, input string name);
        vec_t v;
        v.rst_n = r; v.mem_read = mr; v.idex_rt = irt; v.rs = rs; v.rt = rt;
        v.uses_rt = ur; v.jump = j; v.branch = b; v.busy = bz; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst_n = v.rst_n; idex_mem_read = v.mem_read; idex_rt = v.idex_rt;
        ifid_rs = v.rs; ifid_rt = v.rt; ifid_uses_rt = v.uses_rt;
        id_jump = v.jump; ex_branch_taken = v.branch; mem_busy = v.busy;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        apply(v);
        #2;
        check_val(v.name, {25'd0, state, pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze},
                  {25'd0, v.exp});
        next_cycle();
    endtask

    initial begin
        //              rst mr irt  rs   rt   ur j  b  bz  expected
        vecs[0]  = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RST,   "reset");
        vecs[1]  = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "release_run");
        vecs[2]  = mk(1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, E_STL_R, "lu_rs_bubble1");
        vecs[3]  = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_STL_L, "lu_rs_bubble2");
        vecs[4]  = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "lu_rs_done");
        vecs[5]  = mk(1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, E_RUN,   "reg_zero");
        vecs[6]  = mk(1, 1, 5'd8, 5'd3, 5'd8, 0, 0, 0, 0, E_RUN,   "rt_not_used");
        vecs[7]  = mk(1, 1, 5'd8, 5'd3, 5'd8, 1, 0, 0, 0, E_STL_R, "lu_rt_bubble1");
        vecs[8]  = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_STL_L, "lu_rt_bubble2");
        vecs[9]  = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "lu_rt_done");
        vecs[10] = mk(1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 1, 0, E_BR,    "branch_vs_lu");
        vecs[11] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "branch_no_bubble");
        vecs[12] = mk(1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0, E_JMP,   "jump_vs_lu");
        vecs[13] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "jump_no_bubble");
        vecs[14] = mk(1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, E_STL_R, "mw_bubble1");
        vecs[15] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, E_FRZ_L, "mw_busy1");
        vecs[16] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, E_FRZ_M, "mw_busy2");
        vecs[17] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, E_FRZ_M, "mw_busy3");
        vecs[18] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RET_M, "mw_resume_bubble2");
        vecs[19] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "mw_done");
        vecs[20] = mk(1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 0, E_STL_R, "rst_pre_bubble");
        vecs[21] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RST,   "rst_mid_stall");
        vecs[22] = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "rst_release");

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // Perf sequence: counters were cleared by the reset in the table.
        check_val("cnt_after_reset", {stall_cnt, flush_cnt}, 32'd0);
        run_vec(mk(1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 0, E_STL_R, "perf_bubble1"));
        run_vec(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_STL_L, "perf_bubble2"));
        run_vec(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, E_BR,    "perf_branch"));
        run_vec(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "perf_idle"));
`ifdef HAZARD_PERF_CNT_EN
        check_val("stall_cnt_2", {16'd0, stall_cnt}, 32'd2);
        check_val("flush_cnt_1", {16'd0, flush_cnt}, 32'd1);
`else
        check_val("stall_cnt_off", {16'd0, stall_cnt}, 32'd0);
        check_val("flush_cnt_off", {16'd0, flush_cnt}, 32'd0);
`endif
        // Three more 2-bubble hazards: 8 stalls in total, PERF_W = 2 saturates at 3.
        for (int k = 0; k < 3; k++) begin
            run_vec(mk(1, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0, E_STL_R, "sat_bubble1"));
            run_vec(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_STL_L, "sat_bubble2"));
        end
        run_vec(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN, "sat_idle"));
`ifdef HAZARD_PERF_CNT_EN
        check_val("stall_cnt_8", {16'd0, stall_cnt}, 32'd8);
        check_val("stall_cnt_w2_sat", {30'd0, stall_cnt2}, 32'd3);
        check_val("flush_cnt_w2", {30'd0, flush_cnt2}, 32'd1);
`else
        check_val("stall_cnt_off2", {16'd0, stall_cnt}, 32'd0);
        check_val("stall_cnt_w2_off", {30'd0, stall_cnt2}, 32'd0);
        check_val("flush_cnt_w2_off", {30'd0, flush_cnt2}, 32'd0);
`endif
        check_val("w2_outputs_match", {25'd0, state2, pc_write2, ifid_write2, ifid_flush2,
                  idex_flush2, pipe_freeze2}, {25'd0, E_RUN});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
